// File: rtl/pdes_pkg.sv
// Shared definitions for the PHOLD core monitor slice.
//   - default widths for the monitor and its sub-modules
//   - event message field offsets (time, LP id, anti-message flag, history tag)
//   - null-message constant (anti-message flag set, LP 0, time 0)
package pdes_pkg;

  localparam int unsigned DEF_NUM_CORE      = 16;
  localparam int unsigned DEF_NB_COREID     = 4;
  localparam int unsigned DEF_NUM_LP        = 32;
  localparam int unsigned DEF_NB_LPID       = 5;
  localparam int unsigned DEF_TIME_WID      = 16;
  localparam int unsigned DEF_MSG_WID       = 32;
  localparam int unsigned DEF_NB_HIST_DEPTH = 4;

  localparam int unsigned TIME_LSB   = 0;
  localparam int unsigned LP_LSB     = DEF_TIME_WID;
  localparam int unsigned CANCEL_BIT = DEF_NB_LPID + DEF_TIME_WID;
  localparam int unsigned HIST_LSB   = DEF_MSG_WID - DEF_NB_HIST_DEPTH;

  localparam logic [DEF_MSG_WID-1:0] NULL_MSG = DEF_MSG_WID'(1) << CANCEL_BIT;

endpackage

// File: rtl/pdes_core_monitor_min_time_tree.sv
// min_time_tree: balanced comparator tree returning the smallest valid
// timestamp and whether any input was valid.
//   i_ts  : per-input timestamps
//   i_vld : per-input valid; invalid inputs never win
//   o_min : minimum valid timestamp, all ones when nothing is valid
//   o_any : OR of i_vld
module min_time_tree #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 16
) (
  input  logic [N-1:0][W-1:0] i_ts,
  input  logic [N-1:0]        i_vld,
  output logic [W-1:0]        o_min,
  output logic                o_any
);

  localparam int unsigned LVL = (N > 1) ? $clog2(N) : 0;
  localparam int unsigned P   = 1 << LVL;

  // Heap-indexed tree: node k has children 2k and 2k+1, leaves at P..2P-1.
  logic [W-1:0] w_min [1:2*P-1];
  logic         w_any [1:2*P-1];

  for (genvar l = 0; l < P; l++) begin : g_leaf
    if (l < N) begin : g_real
      assign w_min[P+l] = i_vld[l] ? i_ts[l] : '1;
      assign w_any[P+l] = i_vld[l];
    end else begin : g_pad
      assign w_min[P+l] = '1;
      assign w_any[P+l] = 1'b0;
    end
  end

  for (genvar k = 1; k < P; k++) begin : g_node
    assign w_min[k] = (w_min[2*k] <= w_min[2*k+1]) ? w_min[2*k] : w_min[2*k+1];
    assign w_any[k] = w_any[2*k] | w_any[2*k+1];
  end

  assign o_min = w_min[1];
  assign o_any = w_any[1];

endmodule

// File: rtl/pdes_core_monitor.sv
// pdes_core_monitor: tracks the LP and timestamp each event core is working
// on, stalls cores that would touch an LP out of timestamp order, and reports
// the minimum in-flight timestamp for GVT.
//   clk, rst_n     : clock, asynchronous active-low reset
//   msg            : event message (time, LP id, anti-message flag, history tag)
//   sent_msg_vld   : msg dispatched to core core_id (updates the table)
//   rcv_msg_vld    : core core_id emitting msg (table unaffected)
//   core_id        : core associated with the valid message
//   core_active    : per-core "holds an event"
//   core_hist_cnt  : per-core history occupancy, NB_HIST_DEPTH bits each
//   stall          : per-core hold request
//   min_time       : smallest timestamp over active cores (all ones if none)
//   min_time_vld   : any core active
// Optional feature macro HIST_STALL_EN: also stall a core whose history is
// full, unless it holds the minimum timestamp.
module pdes_core_monitor
  import pdes_pkg::*;
#(
  parameter int unsigned NUM_CORE      = DEF_NUM_CORE,
  parameter int unsigned NB_COREID     = DEF_NB_COREID,
  parameter int unsigned NUM_LP        = DEF_NUM_LP,
  parameter int unsigned NB_LPID       = DEF_NB_LPID,
  parameter int unsigned TIME_WID      = DEF_TIME_WID,
  parameter int unsigned MSG_WID       = DEF_MSG_WID,
  parameter int unsigned NB_HIST_DEPTH = DEF_NB_HIST_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MSG_WID-1:0]                msg,
  input  logic                              sent_msg_vld,
  input  logic                              rcv_msg_vld,
  input  logic [NB_COREID-1:0]              core_id,
  input  logic [NUM_CORE-1:0]               core_active,
  input  logic [NB_HIST_DEPTH*NUM_CORE-1:0] core_hist_cnt,
  output logic [NUM_CORE-1:0]               stall,
  output logic [TIME_WID-1:0]               min_time,
  output logic                              min_time_vld
);

  localparam int unsigned M_LP_LSB = TIME_WID;
  localparam int unsigned M_TOP    = TIME_WID + NB_LPID;

  logic [NB_LPID-1:0]  r_lp [NUM_CORE];
  logic [TIME_WID-1:0] r_ts [NUM_CORE];

  logic [NUM_CORE-1:0]               w_act;
  logic [NUM_CORE-1:0][TIME_WID-1:0] w_ts_flat;
  logic [TIME_WID-1:0]               w_min;
  logic                              w_any;
  logic [NUM_CORE-1:0]               w_stall;

  // Received messages and the cancel/history fields of msg do not affect the table.
  logic w_unused;
  assign w_unused = ^{msg[MSG_WID-1:M_TOP], rcv_msg_vld, core_hist_cnt,
                      (NUM_LP == (1 << NB_LPID))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
        r_lp[i] <= '0;
        r_ts[i] <= '0;
      end
    end else if (sent_msg_vld) begin
      r_lp[core_id] <= msg[M_LP_LSB +: NB_LPID];
      r_ts[core_id] <= msg[TIME_WID-1:0];
    end
  end

  // Gating activity with rst_n keeps all outputs idle while reset is held,
  // regardless of what core_active shows.
  assign w_act = core_active & {NUM_CORE{rst_n}};

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORE; i++) begin
      w_ts_flat[i] = r_ts[i];
    end
  end

  min_time_tree #(
    .N (NUM_CORE),
    .W (TIME_WID)
  ) u_min_tree (
    .i_ts  (w_ts_flat),
    .i_vld (w_act),
    .o_min (w_min),
    .o_any (w_any)
  );

  // A core yields to any other active core on the same LP that is older,
  // or equally old with a lower index, leaving one runnable core per LP.
  always_comb begin
    w_stall = '0;
    for (int unsigned i = 0; i < NUM_CORE; i++) begin
      for (int unsigned j = 0; j < NUM_CORE; j++) begin
        if (j != i && w_act[i] && w_act[j] && r_lp[j] == r_lp[i] &&
            (r_ts[j] < r_ts[i] || (r_ts[j] == r_ts[i] && j < i))) begin
          w_stall[i] = 1'b1;
        end
      end
`ifdef HIST_STALL_EN
      // The core at GVT is exempt so the simulation always makes progress.
      if (w_act[i] && (&core_hist_cnt[i*NB_HIST_DEPTH +: NB_HIST_DEPTH]) &&
          r_ts[i] != w_min) begin
        w_stall[i] = 1'b1;
      end
`endif
    end
  end

  assign stall        = w_stall;
  assign min_time     = w_min;
  assign min_time_vld = w_any;

endmodule

// File: tb/tb_pdes_core_monitor.sv
module tb_pdes_core_monitor;
  import pdes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] msg;
  logic        sent_msg_vld;
  logic        rcv_msg_vld;
  logic [3:0]  core_id;
  logic [15:0] core_active;
  logic [63:0] core_hist_cnt;
  logic [15:0] stall;
  logic [15:0] min_time;
  logic        min_time_vld;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pdes_core_monitor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .msg           (msg),
    .sent_msg_vld  (sent_msg_vld),
    .rcv_msg_vld   (rcv_msg_vld),
    .core_id       (core_id),
    .core_active   (core_active),
    .core_hist_cnt (core_hist_cnt),
    .stall         (stall),
    .min_time      (min_time),
    .min_time_vld  (min_time_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // History tag bits are filled with junk to show they are ignored.
  function automatic logic [31:0] mk_msg(input int unsigned lp, input int unsigned t);
    logic [31:0] m;
    m = '0;
    m[LP_LSB +: 5]   = lp[4:0];
    m[15:0]          = t[15:0];
    m[HIST_LSB +: 4] = 4'hA;
    return m;
  endfunction

  task automatic xfer(input logic snd, input logic rcv, input int unsigned cid,
                      input int unsigned lp, input int unsigned t);
    @(negedge clk);
    msg          = mk_msg(lp, t);
    core_id      = cid[3:0];
    sent_msg_vld = snd;
    rcv_msg_vld  = rcv;
    @(posedge clk);
    #1;
    sent_msg_vld = 1'b0;
    rcv_msg_vld  = 1'b0;
  endtask

  task automatic set_active(input logic [15:0] a);
    core_active = a;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; msg = '0; sent_msg_vld = 1'b0; rcv_msg_vld = 1'b0;
    core_id = '0; core_active = '0; core_hist_cnt = '0;
    #12;
    check("rst_stall", {16'h0, stall}, 32'h0);
    check("rst_vld", {31'h0, min_time_vld}, 32'h0);
    check("rst_min", {16'h0, min_time}, 32'hFFFF);
    set_active(16'hFFFF);
    check("rst_act_stall", {16'h0, stall}, 32'h0);
    check("rst_act_vld", {31'h0, min_time_vld}, 32'h0);
    check("rst_act_min", {16'h0, min_time}, 32'hFFFF);
    set_active(16'h0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("idle_vld", {31'h0, min_time_vld}, 32'h0);
    check("idle_min", {16'h0, min_time}, 32'hFFFF);

    // Same LP, core 5 older than core 2.
    xfer(1, 0, 2, 3, 100);
    xfer(1, 0, 5, 3, 50);
    set_active(16'h0024);
    check("lp3_stall", {16'h0, stall}, 32'h0004);
    check("lp3_min", {16'h0, min_time}, 32'd50);
    check("lp3_vld", {31'h0, min_time_vld}, 32'h1);

    // Equal timestamps on LP7: lower index (core 1) wins.
    xfer(1, 0, 1, 7, 80);
    xfer(1, 0, 4, 7, 80);
    set_active(16'h0036);
    check("tie_stall", {16'h0, stall}, 32'h0014);
    check("tie_min", {16'h0, min_time}, 32'd50);
    set_active(16'h0034);
    check("tie_deact", {16'h0, stall}, 32'h0004);

    // Distinct LPs, t = 1000 - 10*i.
    for (int unsigned i = 0; i < 16; i++) xfer(1, 0, i, i, 1000 - i * 10);
    set_active(16'hFFFF);
    check("dist_stall", {16'h0, stall}, 32'h0);
    check("dist_min", {16'h0, min_time}, 32'd850);
    set_active(16'h7FFF);
    check("dist_min15off", {16'h0, min_time}, 32'd860);
    set_active(16'h0);
    check("none_vld", {31'h0, min_time_vld}, 32'h0);
    check("none_min", {16'h0, min_time}, 32'hFFFF);

    // Simultaneous sent+rcv: the dispatch is written.
    xfer(1, 1, 3, 9, 20);
    set_active(16'h0008);
    check("both_min", {16'h0, min_time}, 32'd20);
    set_active(16'h0208);
    check("both_lp", {16'h0, stall}, 32'h0200);
    xfer(0, 1, 3, 11, 5);
    check("rcv_min", {16'h0, min_time}, 32'd20);
    check("rcv_lp", {16'h0, stall}, 32'h0200);

    // Three cores on LP9: cores 3 and 7 tie at 20, core 9 at 910.
    xfer(1, 0, 7, 9, 20);
    set_active(16'h0288);
    check("tie3_stall", {16'h0, stall}, 32'h0280);
    check("tie3_min", {16'h0, min_time}, 32'd20);

    // Mid-operation reset clears the table.
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {16'h0, stall}, 32'h0);
    check("mid_rst_vld", {31'h0, min_time_vld}, 32'h0);
    check("mid_rst_min", {16'h0, min_time}, 32'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    set_active(16'hFFFF);
    check("cleared_stall", {16'h0, stall}, 32'hFFFE);
    check("cleared_min", {16'h0, min_time}, 32'd0);
    set_active(16'h0);

    // History-full stall, exempt when holding the minimum.
    xfer(1, 0, 6, 6, 200);
    xfer(1, 0, 0, 0, 100);
    core_hist_cnt = 64'h0F00_0000;
    set_active(16'h0041);
`ifdef HIST_STALL_EN
    check("hist_stall", {16'h0, stall}, 32'h0040);
`else
    check("hist_ignored", {16'h0, stall}, 32'h0);
`endif
    check("hist_min", {16'h0, min_time}, 32'd100);
    set_active(16'h0040);
    check("hist_gvt", {16'h0, stall}, 32'h0);
    check("hist_gvt_min", {16'h0, min_time}, 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
